// File: rtl/ysyx_axi4_mem_slave.sv
// AXI4 slave backed by a 64-bit word array, so the core can be simulated without the SoC.
// Define YSYX_AXI_SLAVE_DELAY_EN to add LFSR-driven random stalls on the handshakes.
module ysyx_axi4_mem_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 64,
    parameter int                ID_W      = 4,
    parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h80000000,
    parameter int                MEM_WORDS = 4096,
    parameter int                RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          arburst,
    input  logic [2:0]          arsize,
    input  logic [7:0]          arlen,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready_o,
    output logic [ID_W-1:0]     rid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          rresp_o,
    output logic                rlast_o,
    output logic                rvalid_o,
    input  logic                rready,
    input  logic [1:0]          awburst,
    input  logic [2:0]          awsize,
    input  logic [7:0]          awlen,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready_o,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready_o,
    output logic [ID_W-1:0]     bid_o,
    output logic [1:0]          bresp_o,
    output logic                bvalid_o,
    input  logic                bready
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_W:0] RANGE_LO = {1'b0, MEM_BASE};
    localparam logic [ADDR_W:0] RANGE_HI = RANGE_LO + (ADDR_W+1)'(MEM_WORDS * 8);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    r_state_t          r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len, r_beat;
    logic [1:0]        r_burst;
    logic [3:0]        r_wait;
    logic              ar_rdy;

    w_state_t          w_state;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len, w_beat;
    logic [1:0]        w_burst;
    logic              w_err, aw_rdy, w_rdy, mem_we, gate;

    logic unused_sizes;
    assign unused_sizes = ^{arsize, awsize};

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} >= RANGE_LO) && ({1'b0, a} < RANGE_HI);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - MEM_BASE) >> 3);
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + ADDR_W'(8);
    endfunction

    function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
        return in_range(a) ? mem[word_idx(a)] : '0;
    endfunction

`ifdef YSYX_AXI_SLAVE_DELAY_EN
    logic [19:0] lfsr;
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 20'd1;
        else     lfsr <= {lfsr[18:0], lfsr[19] ^ lfsr[18]};
    end
    assign gate = lfsr[19];
`else
    assign gate = 1'b1;
`endif

    assign arready_o = ar_rdy & gate;
    assign awready_o = aw_rdy & gate;
    assign wready_o  = w_rdy & gate;

    // Nonblocking array update: a read of the same word this cycle still sees the old data.
    assign mem_we = !rst && (w_state == W_DATA) && wvalid && wready_o && in_range(w_addr);
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= R_IDLE;
            ar_rdy   <= 1'b1;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            rresp_o  <= 2'b00;
            rlast_o  <= 1'b0;
            rid_o    <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_burst  <= 2'b00;
            r_wait   <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (arvalid && arready_o) begin
                    r_addr  <= araddr;
                    r_len   <= arlen;
                    rid_o   <= arid;
                    r_burst <= arburst;
                    r_beat  <= '0;
                    ar_rdy  <= 1'b0;
                    if (RD_LAT == 0) begin
                        rdata_o  <= rd_word(araddr);
                        rresp_o  <= in_range(araddr) ? 2'b00 : 2'b10;
                        rlast_o  <= (arlen == 8'd0);
                        rvalid_o <= 1'b1;
                        r_state  <= R_DATA;
                    end else begin
                        r_wait  <= 4'(RD_LAT - 1);
                        r_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_wait != 4'd0) begin
                        r_wait <= r_wait - 4'd1;
                    end else if (gate) begin
                        rdata_o  <= rd_word(r_addr);
                        rresp_o  <= in_range(r_addr) ? 2'b00 : 2'b10;
                        rlast_o  <= (r_len == 8'd0);
                        rvalid_o <= 1'b1;
                        r_state  <= R_DATA;
                    end
                end
                R_DATA: if (rready) begin
                    if (rlast_o) begin
                        rvalid_o <= 1'b0;
                        rlast_o  <= 1'b0;
                        ar_rdy   <= 1'b1;
                        r_state  <= R_IDLE;
                    end else begin
                        r_addr  <= next_addr(r_addr, r_burst);
                        r_beat  <= r_beat + 8'd1;
                        rdata_o <= rd_word(next_addr(r_addr, r_burst));
                        rresp_o <= in_range(next_addr(r_addr, r_burst)) ? 2'b00 : 2'b10;
                        rlast_o <= (r_beat + 8'd1 == r_len);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // A burst ends on wlast or on beat awlen; disagreement between the two is reported as SLVERR.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state  <= W_IDLE;
            aw_rdy   <= 1'b1;
            w_rdy    <= 1'b0;
            bvalid_o <= 1'b0;
            bresp_o  <= 2'b00;
            bid_o    <= '0;
            w_addr   <= '0;
            w_len    <= '0;
            w_beat   <= '0;
            w_burst  <= 2'b00;
            w_err    <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (awvalid && awready_o) begin
                    w_addr  <= awaddr;
                    w_len   <= awlen;
                    bid_o   <= awid;
                    w_burst <= awburst;
                    w_beat  <= '0;
                    w_err   <= 1'b0;
                    aw_rdy  <= 1'b0;
                    w_rdy   <= 1'b1;
                    w_state <= W_DATA;
                end
                W_DATA: if (wvalid && wready_o) begin
                    if (wlast || (w_beat == w_len)) begin
                        w_rdy    <= 1'b0;
                        bvalid_o <= 1'b1;
                        bresp_o  <= (w_err || !in_range(w_addr) || (wlast != (w_beat == w_len)))
                                    ? 2'b10 : 2'b00;
                        w_state  <= W_RESP;
                    end else begin
                        w_addr <= next_addr(w_addr, w_burst);
                        w_beat <= w_beat + 8'd1;
                        if (!in_range(w_addr)) w_err <= 1'b1;
                    end
                end
                W_RESP: if (bready) begin
                    bvalid_o <= 1'b0;
                    bresp_o  <= 2'b00;
                    aw_rdy   <= 1'b1;
                    w_state  <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end
endmodule

// File: doc/ysyx_axi4_mem_slave.md
Name: ysyx_axi4_mem_slave

Overview:
- AXI4 responder that answers the core's AXI4 master bus, i.e. the arbiter's io_master_* port.
- Backed by an internal 64-bit-wide memory array, so the core can be simulated standalone without the SoC.
- Read and write channels run as independent FSMs and may be active at the same time.
- Supports single-beat and INCR/FIXED bursts, byte strobes, and an error response for out-of-range addresses.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data bus width (fixed at 64; other values are unsupported)
ID_W, 4, AXI ID width
MEM_BASE, 32'h80000000, byte address of memory word 0
MEM_WORDS, 4096, array depth in 64-bit words (power of two)
RD_LAT, 1, extra idle cycles between AR handshake and first R beat (0..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
arburst  in  2  read burst type
arsize  in  3  read beat size (ignored; full word returned)
arlen  in  8  read beats minus 1
arid  in  ID_W  read ID
araddr  in  ADDR_W  read address
arvalid  in  1  AR valid
arready_o  out  1  AR ready
rid_o  out  ID_W  echoed arid
rdata_o  out  64  read data
rresp_o  out  2  read response
rlast_o  out  1  last read beat
rvalid_o  out  1  R valid
rready  in  1  R ready
awburst  in  2  write burst type
awsize  in  3  write size (ignored; wstrb governs)
awlen  in  8  write beats minus 1
awid  in  ID_W  write ID
awaddr  in  ADDR_W  write address
awvalid  in  1  AW valid
awready_o  out  1  AW ready
wdata  in  64  write data
wstrb  in  8  byte enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready_o  out  1  W ready
bid_o  out  ID_W  echoed awid
bresp_o  out  2  write response
bvalid_o  out  1  B valid
bready  in  1  B ready

Behaviour:
- Reset (rst high at posedge): both FSMs go to IDLE. All *_o outputs are 0, except arready_o=1 and awready_o=1. Memory contents are not cleared. Reset mid-burst abandons the burst; no B or R beat is issued.

- Word index: (addr - MEM_BASE) >> 3, truncated to log2(MEM_WORDS) bits.
- In range: MEM_BASE <= addr < MEM_BASE + 8*MEM_WORDS, checked per beat.
- Out-of-range read beat: rdata_o=0, rresp_o=2'b10 (SLVERR).
- Out-of-range write beat: data dropped; the burst's bresp_o becomes 2'b10.

- Read FSM: R_IDLE -> R_WAIT -> R_DATA.
  - R_IDLE: arready_o=1. On arvalid, latch araddr/arlen/arid/arburst. Go to R_WAIT if RD_LAT>0, else R_DATA.
  - R_WAIT: arready_o=0. Count RD_LAT cycles, then go to R_DATA.
  - R_DATA: rvalid_o=1. rdata_o is the array word at the current address; rlast_o=1 on beat arlen.
  - On rvalid_o & rready: advance the address (+8 for INCR 2'b01 and WRAP 2'b10; unchanged for FIXED 2'b00) and the beat count.
  - After the last beat, return to R_IDLE; the next AR is accepted one cycle later.
  - rready low holds rvalid_o and rdata_o stable.

- Write FSM: W_IDLE -> W_DATA -> W_RESP.
  - W_IDLE: awready_o=1, wready_o=0. On awvalid, latch awaddr/awlen/awid/awburst and go to W_DATA.
  - W_DATA: wready_o=1. On wvalid, write the bytes whose wstrb bit is set; the write is visible to reads from the next cycle. Address advances as for reads.
  - W_DATA exits to W_RESP on wlast, or when the beat count reaches awlen, whichever comes first. A wlast/awlen mismatch sets bresp_o=2'b10.
  - W_RESP: bvalid_o=1 until bready, then go to W_IDLE.
  - bresp_o is 2'b00 unless an error was recorded.

- Read/write collision on the same word in the same cycle: the R beat returns the old data.
- AW and W arriving in the same cycle: W is not accepted until the cycle after the AW handshake.

Optional Feature:
YSYX_AXI_SLAVE_DELAY_EN:
- Defined: a 20-bit LFSR (seed 1, feedback bit19^bit18, stepped every cycle) gates the handshakes. arready_o, awready_o and wready_o are additionally ANDed with lfsr[19]. Entry into R_DATA and W_RESP is postponed until lfsr[19]=1. This randomises the delays seen by the master.
- Undefined: timing is exactly as described above.

Test Plan:
- Write then read: AW 0x80000008 len0 with W 0x1122334455667788, strb 0xFF -> B resp 0, bid echoed. Then AR 0x80000008 -> rdata 0x1122334455667788, rlast=1, first R beat RD_LAT+1 cycles after the AR handshake.
- Byte strobe: write 0xAABBCCDD_00000000 with strb 0xF0 over a word of all 0xFF -> read returns 0xAABBCCDD_FFFFFFFF.
- INCR read burst: AR 0x80000000 len3 with rready toggled 1,0,1,... -> 4 beats at words 0..3, rlast only on beat 3, data held stable while rready=0.
- Out of range: AR 0x7FFFFFF8 -> rresp 2'b10, rdata 0. AW 0x90000000 -> bresp 2'b10 and the array is unchanged.
- Concurrency and reset: a 4-beat read overlapping a 2-beat write both complete with correct IDs. Asserting rst during beat 2 of the read gives rvalid_o=0 and arready_o=1 on the next cycle.
- With YSYX_AXI_SLAVE_DELAY_EN defined: 100 random transactions return data identical to a reference model, and no handshake deadlocks.
